// File: rtl/stream_demux_if.sv
// stream_demux_if -- handshake/bus bundle for the stream demultiplexer.
//   in_valid / in_ready            : input beat handshake
//   in_data  [DATA_W]              : payload of the offered beat
//   in_sel   [SEL_W]               : destination channel index
//   in_bcast                       : deliver to every channel (overrides in_sel)
//   out_valid / out_ready [N_CH]   : per-channel output handshake
//   out_data [N_CH*DATA_W]         : channel k at [k*DATA_W +: DATA_W]
// Modports: master = source/sink side, slave = the demultiplexer.
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8
);
  localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_bcast;
  logic [N_CH-1:0]          out_valid;
  logic [N_CH-1:0]          out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux.sv
// stream_demux -- routes one input stream to N_CH output channels, each
// backed by a single holding register. Supports unicast, broadcast (all
// channels load together or none do) and counts out-of-range beats.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : when low no new beat is accepted; held beats still drain
//   bus     : stream_demux_if.slave handshake/data bundle
//   err_cnt : saturating count of dropped out-of-range beats
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  stream_demux_if.slave  bus,
  output logic [7:0]     err_cnt
);
  localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1;
  // One extra bit so N_CH itself is representable for the range compare.
  localparam logic [SEL_W:0] LP_NCH = (SEL_W + 1)'(N_CH);

  logic [N_CH-1:0]        r_valid;
  logic [N_CH*DATA_W-1:0] r_data;
  logic [7:0]             r_err_cnt;

  logic [N_CH-1:0]        w_free;
  logic [N_CH-1:0]        w_load;
  logic                   w_sel_free;
  logic                   w_oor;
  logic                   w_ready;
  logic                   w_accept;

  // Channel-free flags, acceptance decision and per-channel load strobes.
  always_comb begin
    // A full channel whose sink takes its beat this cycle can be reloaded.
    w_free     = ~r_valid | bus.out_ready;
    w_sel_free = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      w_sel_free = w_sel_free | ((bus.in_sel == SEL_W'(k)) & w_free[k]);
    end
    w_oor = ~bus.in_bcast & ({1'b0, bus.in_sel} >= LP_NCH);

    if (!rst_n) begin
      w_ready = 1'b0;
    end else if (!en) begin
      w_ready = 1'b0;
    end else if (bus.in_bcast) begin
      w_ready = &w_free;
    end else if (w_oor) begin
      w_ready = 1'b1;
    end else begin
      w_ready = w_sel_free;
    end

    w_accept = bus.in_valid & w_ready;
    w_load   = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_load[k] = w_accept & (bus.in_bcast | (~w_oor & (bus.in_sel == SEL_W'(k))));
    end
  end

  // Holding registers and the saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_data    <= '0;
      r_err_cnt <= 8'd0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_load[k]) begin
          r_valid[k]                    <= 1'b1;
          r_data[k*DATA_W +: DATA_W]    <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          r_valid[k]                    <= 1'b0;
        end else begin
          r_valid[k]                    <= r_valid[k];
        end
      end
      if (w_accept && w_oor && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign err_cnt       = r_err_cnt;
endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] err8;
  logic [7:0] err6;
  int total;
  int bad;

  stream_demux_if #(.DATA_W(8), .N_CH(8)) bus8();
  stream_demux_if #(.DATA_W(8), .N_CH(6)) bus6();

  stream_demux #(.DATA_W(8), .N_CH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus8), .err_cnt(err8));
  stream_demux #(.DATA_W(8), .N_CH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus6), .err_cnt(err6));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model of the 8-channel instance: one optional beat per channel.
  logic       exp_v [8];
  logic [7:0] exp_d [8];

  function automatic logic model_ready();
    logic all_free;
    all_free = 1'b1;
    for (int k = 0; k < 8; k++) if (exp_v[k] && !bus8.out_ready[k]) all_free = 1'b0;
    if (!en) return 1'b0;
    if (bus8.in_bcast) return all_free;
    return !exp_v[bus8.in_sel] || bus8.out_ready[bus8.in_sel];
  endfunction

  function automatic logic [7:0] model_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = exp_v[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin exp_v[k] = 1'b0; exp_d[k] = 8'h00; end
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick();
    logic acc;
    acc = bus8.in_valid && model_ready();
    for (int k = 0; k < 8; k++) if (exp_v[k] && bus8.out_ready[k]) exp_v[k] = 1'b0;
    if (acc) begin
      if (bus8.in_bcast) begin
        for (int k = 0; k < 8; k++) begin exp_v[k] = 1'b1; exp_d[k] = bus8.in_data; end
      end else begin
        exp_v[bus8.in_sel] = 1'b1;
        exp_d[bus8.in_sel] = bus8.in_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 8'hFF;
    tick();
    bus8.out_ready = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    bus8.in_valid = 1'b1; bus8.in_sel = 3'd0; bus8.in_bcast = 1'b0;
    bus8.in_data = 8'hFF; bus8.out_ready = 8'h00;
    bus6.in_valid = 1'b0; bus6.in_sel = 3'd0; bus6.in_bcast = 1'b0;
    bus6.in_data = 8'h00; bus6.out_ready = 6'h00;
    model_clear();
    #1;
    total++; if (bus8.out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=00", bus8.out_valid); end
    total++; if (bus8.out_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus8.out_data); end
    total++; if (err8 !== 8'h00) begin bad++; $display("FAIL reset_err got=%h exp=00", err8); end
    total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus8.in_ready); end
    @(posedge clk); #1;
    total++; if (bus8.out_valid !== 8'h00) begin bad++; $display("FAIL reset_hold got=%h exp=00", bus8.out_valid); end
    bus8.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bus8.in_valid = 1'b1; bus8.in_sel = 3'd3; bus8.in_data = 8'hA5; bus8.out_ready = 8'h00;
    #1;
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", bus8.in_ready); end
    tick();
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus8.out_valid !== 8'h08) begin bad++; $display("FAIL basic_valid got=%h exp=08", bus8.out_valid); end
      total++; if (bus8.out_data[24 +: 8] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", bus8.out_data[24 +: 8]); end
      tick();
    end
    bus8.out_ready = 8'h08;
    tick();
    bus8.out_ready = 8'h00;
    total++; if (bus8.out_valid !== 8'h00) begin bad++; $display("FAIL basic_drain got=%h exp=00", bus8.out_valid); end
  endtask

  task automatic test_stall();
    bus8.in_valid = 1'b1; bus8.in_sel = 3'd2; bus8.in_data = 8'h11; bus8.out_ready = 8'h00;
    tick();
    bus8.in_data = 8'h22;
    #1;
    total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", bus8.in_ready); end
    tick();
    total++; if (bus8.out_data[16 +: 8] !== 8'h11 || bus8.out_valid !== 8'h04) begin bad++; $display("FAIL stall_hold got=%h/%h exp=04/11", bus8.out_valid, bus8.out_data[16 +: 8]); end
    bus8.out_ready = 8'h04;
    #1;
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL stall_reload_ready got=%b exp=1", bus8.in_ready); end
    tick();
    total++; if (bus8.out_data[16 +: 8] !== 8'h22 || bus8.out_valid !== 8'h04) begin bad++; $display("FAIL stall_reload got=%h/%h exp=04/22", bus8.out_valid, bus8.out_data[16 +: 8]); end
    drain_all();
  endtask

  task automatic test_bcast();
    bus8.in_valid = 1'b1; bus8.in_sel = 3'd5; bus8.in_data = 8'h55; bus8.in_bcast = 1'b0;
    tick();
    bus8.in_bcast = 1'b1; bus8.in_sel = 3'd0; bus8.in_data = 8'h3C;
    #1;
    total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("FAIL bcast_block_ready got=%b exp=0", bus8.in_ready); end
    tick();
    total++; if (bus8.out_valid !== 8'h20) begin bad++; $display("FAIL bcast_partial got=%h exp=20", bus8.out_valid); end
    bus8.out_ready = 8'h20;
    #1;
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL bcast_ready got=%b exp=1", bus8.in_ready); end
    tick();
    bus8.in_valid = 1'b0; bus8.in_bcast = 1'b0; bus8.out_ready = 8'h00;
    total++; if (bus8.out_valid !== 8'hFF) begin bad++; $display("FAIL bcast_valid got=%h exp=ff", bus8.out_valid); end
    total++; if (bus8.out_data !== {8{8'h3C}}) begin bad++; $display("FAIL bcast_data got=%h", bus8.out_data); end
    drain_all();
  endtask

  task automatic test_enable();
    bus8.in_valid = 1'b1; bus8.in_sel = 3'd1; bus8.in_data = 8'h99;
    tick();
    en = 1'b0; bus8.in_sel = 3'd0;
    #1;
    total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("FAIL en_ready got=%b exp=0", bus8.in_ready); end
    bus8.out_ready = 8'h02;
    tick();
    total++; if (bus8.out_valid !== 8'h00) begin bad++; $display("FAIL en_drain got=%h exp=00", bus8.out_valid); end
    en = 1'b1; bus8.in_valid = 1'b0; bus8.out_ready = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    bus8.out_ready = 8'hFF; bus8.in_valid = 1'b1; bus8.in_bcast = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      bus8.in_sel = 3'(i % 8); bus8.in_data = d;
      #1;
      total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus8.in_ready); end
      tick();
      total++; if (bus8.out_valid !== (8'h01 << (i % 8)) || bus8.out_data[(i % 8)*8 +: 8] !== d) begin
        bad++; $display("FAIL b2b_deliver i=%0d got=%h/%h exp=%h/%h", i, bus8.out_valid, bus8.out_data[(i % 8)*8 +: 8], 8'h01 << (i % 8), d);
      end
    end
    drain_all();
  endtask

  task automatic test_oor();
    bus6.in_valid = 1'b1; bus6.in_sel = 3'd7; bus6.in_bcast = 1'b0; bus6.out_ready = 6'h00;
    for (int i = 1; i <= 300; i++) begin
      bus6.in_data = 8'($urandom);
      #1;
      total++; if (bus6.in_ready !== 1'b1) begin bad++; $display("FAIL oor_ready i=%0d got=%b exp=1", i, bus6.in_ready); end
      tick();
      total++; if (err6 !== ((i > 255) ? 8'd255 : 8'(i))) begin bad++; $display("FAIL oor_err i=%0d got=%0d", i, err6); end
    end
    total++; if (bus6.out_valid !== 6'h00) begin bad++; $display("FAIL oor_valid got=%h exp=00", bus6.out_valid); end
    bus6.in_sel = 3'd5; bus6.in_data = 8'h77;
    tick();
    bus6.in_valid = 1'b0;
    total++; if (bus6.out_valid !== 6'h20 || bus6.out_data[40 +: 8] !== 8'h77) begin bad++; $display("FAIL oor_top_channel got=%h/%h exp=20/77", bus6.out_valid, bus6.out_data[40 +: 8]); end
    total++; if (err6 !== 8'd255) begin bad++; $display("FAIL oor_sat_hold got=%0d exp=255", err6); end
  endtask

  task automatic test_async_reset();
    bus8.in_valid = 1'b1; bus8.in_sel = 3'd0; bus8.in_data = 8'h10;
    tick();
    bus8.in_sel = 3'd7; bus8.in_data = 8'h70;
    tick();
    bus8.in_valid = 1'b0;
    total++; if (bus8.out_valid !== 8'h81) begin bad++; $display("FAIL areset_pre got=%h exp=81", bus8.out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus8.out_valid !== 8'h00 || bus8.out_data !== 64'h0) begin bad++; $display("FAIL areset_out got=%h/%h", bus8.out_valid, bus8.out_data); end
    total++; if (err6 !== 8'h00 || bus6.out_valid !== 6'h00) begin bad++; $display("FAIL areset_err got=%h/%h exp=00/00", err6, bus6.out_valid); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b1; bus8.in_sel = 3'd4; bus8.in_data = 8'h44;
    tick();
    bus8.in_valid = 1'b0;
    total++; if (bus8.out_valid !== 8'h10 || bus8.out_data[32 +: 8] !== 8'h44) begin bad++; $display("FAIL areset_restart got=%h/%h exp=10/44", bus8.out_valid, bus8.out_data[32 +: 8]); end
    drain_all();
  endtask

  task automatic test_random();
    logic [7:0] ev;
    for (int i = 0; i < 400; i++) begin
      en             = ($urandom_range(0, 7) != 0);
      bus8.in_valid  = 1'($urandom);
      bus8.in_sel    = 3'($urandom);
      bus8.in_bcast  = ($urandom_range(0, 9) == 0);
      bus8.in_data   = 8'($urandom);
      bus8.out_ready = 8'($urandom);
      #1;
      total++; if (bus8.in_ready !== model_ready()) begin bad++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, bus8.in_ready, model_ready()); end
      ev = model_vec();
      total++; if (bus8.out_valid !== ev) begin bad++; $display("FAIL rand_valid i=%0d got=%h exp=%h", i, bus8.out_valid, ev); end
      for (int k = 0; k < 8; k++) begin
        if (exp_v[k]) begin
          total++; if (bus8.out_data[k*8 +: 8] !== exp_d[k]) begin bad++; $display("FAIL rand_data i=%0d ch=%0d got=%h exp=%h", i, k, bus8.out_data[k*8 +: 8], exp_d[k]); end
        end
      end
      tick();
    end
    total++; if (err8 !== 8'h00) begin bad++; $display("FAIL rand_err got=%h exp=00", err8); end
    en = 1'b1;
    drain_all();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_stall();
    test_bcast();
    test_enable();
    test_back_to_back();
    test_oor();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
